// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : State, opcode, instruction-class and output encodings shared by
//            the multi-cycle RV32 control unit and its decoder.
// Revision : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ADDI   = 7'b0010011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [2:0] c_F3_ADD  = 3'b000;
    localparam logic [2:0] c_F3_WORD = 3'b010;
    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [6:0] c_F7_ADD  = 7'b0000000;
    localparam logic [6:0] c_F7_SUB  = 7'b0100000;

    // Bit positions of the one-hot instruction-class vector.
    localparam int c_CLS_ADD  = 0;
    localparam int c_CLS_SUB  = 1;
    localparam int c_CLS_ADDI = 2;
    localparam int c_CLS_LUI  = 3;
    localparam int c_CLS_JAL  = 4;
    localparam int c_CLS_LW   = 5;
    localparam int c_CLS_SW   = 6;
    localparam int c_CLS_BEQ  = 7;
    localparam int c_NUM_CLS  = 8;

    localparam logic [1:0] c_WSEL_ALU = 2'd0;
    localparam logic [1:0] c_WSEL_MEM = 2'd1;
    localparam logic [1:0] c_WSEL_IMM = 2'd2;
    localparam logic [1:0] c_WSEL_PC4 = 2'd3;

    localparam logic c_PCSEL_SEQ = 1'b0;
    localparam logic c_PCSEL_REL = 1'b1;

    localparam logic [1:0] c_FAULT_NONE    = 2'd0;
    localparam logic [1:0] c_FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] c_FAULT_TIMEOUT = 2'd2;

    function automatic logic is_mem_cls(input logic [c_NUM_CLS-1:0] cls);
        return cls[c_CLS_LW] | cls[c_CLS_SW];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational decode of the instruction register into a one-hot
//            class, a sign-extended immediate and an illegal flag.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          i_ir,
    output logic [c_NUM_CLS-1:0] o_cls,
    output logic [XLEN-1:0]      o_imm,
    output logic                 o_illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm32;

    assign w_opcode = i_ir[6:0];
    assign w_funct3 = i_ir[14:12];
    assign w_funct7 = i_ir[31:25];

    // Unsupported encodings leave the class vector empty and the immediate 0.
    always_comb begin
        o_cls   = '0;
        w_imm32 = '0;
        case (w_opcode)
            c_OP_RTYPE: begin
                if (w_funct3 == c_F3_ADD && w_funct7 == c_F7_ADD) begin
                    o_cls[c_CLS_ADD] = 1'b1;
                end else if (w_funct3 == c_F3_ADD && w_funct7 == c_F7_SUB) begin
                    o_cls[c_CLS_SUB] = 1'b1;
                end
            end
            c_OP_ADDI: begin
                if (w_funct3 == c_F3_ADD) begin
                    o_cls[c_CLS_ADDI] = 1'b1;
                    w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
                end
            end
            c_OP_LUI: begin
                o_cls[c_CLS_LUI] = 1'b1;
                w_imm32 = {i_ir[31:12], 12'b0};
            end
            c_OP_JAL: begin
                o_cls[c_CLS_JAL] = 1'b1;
                w_imm32 = {{12{i_ir[31]}}, i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
            end
            c_OP_LOAD: begin
                if (w_funct3 == c_F3_WORD) begin
                    o_cls[c_CLS_LW] = 1'b1;
                    w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
                end
            end
            c_OP_STORE: begin
                if (w_funct3 == c_F3_WORD) begin
                    o_cls[c_CLS_SW] = 1'b1;
                    w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
                end
            end
            c_OP_BRANCH: begin
                if (w_funct3 == c_F3_BEQ) begin
                    o_cls[c_CLS_BEQ] = 1'b1;
                    w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
                end
            end
            default: ;
        endcase
    end

    assign o_imm     = XLEN'($signed(w_imm32));
    assign o_illegal = ~|o_cls;

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_unit
// Brief    : Multi-cycle RV32 control FSM: fetch, decode, execute, memory,
//            with bus timeout fault, single-step and retired-instruction count.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BUS_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_step,
    input  logic [31:0]      i_instr,
    input  logic             i_bus_rdata_valid,
    input  logic             i_bus_write_done,
    input  logic             i_alu_zero,
    output logic [4:0]       o_reg_rs1,
    output logic [4:0]       o_reg_rs2,
    output logic [4:0]       o_reg_rd,
    output logic             o_reg_wen,
    output logic [1:0]       o_reg_wsel,
    output logic [XLEN-1:0]  o_imm,
    output logic             o_alu_op,
    output logic             o_alu_a_sel,
    output logic             o_alu_b_sel,
    output logic             o_pc_en,
    output logic             o_pc_sel,
    output logic             o_bus_start,
    output logic             o_bus_we,
    output logic             o_bus_addr_sel,
    output logic [2:0]       o_state,
    output logic             o_halted,
    output logic [1:0]       o_fault,
    output logic [CNT_W-1:0] o_instr_count
);

    localparam int                  c_WAIT_W    = $clog2(BUS_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(BUS_TIMEOUT - 1);

    state_t                r_state;
    logic [31:0]           r_ir;
    logic [c_WAIT_W-1:0]   r_wait;
    logic                  r_first;
    logic [CNT_W-1:0]      r_count;
    logic [1:0]            r_fault;

    logic [c_NUM_CLS-1:0]  w_cls;
    logic                  w_illegal;
    logic                  w_is_mem;
    logic                  w_mem_ack;
    logic                  w_timeout;
    logic                  w_retire;

    ctrl_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_ir      (r_ir),
        .o_cls     (w_cls),
        .o_imm     (o_imm),
        .o_illegal (w_illegal)
    );

    assign w_is_mem  = is_mem_cls(w_cls);
    assign w_mem_ack = w_cls[c_CLS_SW] ? i_bus_write_done : i_bus_rdata_valid;
    assign w_timeout = (r_wait == c_WAIT_LAST);
    assign w_retire  = ((r_state == ST_EXEC) && !w_is_mem) ||
                       ((r_state == ST_MEM) && w_mem_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
            r_wait  <= '0;
            r_first <= 1'b0;
            r_count <= '0;
            r_fault <= c_FAULT_NONE;
        end else begin
            r_first <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_run || i_step) begin
                        r_state <= ST_FETCH;
                        r_wait  <= '0;
                        r_first <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // An ack on the last wait cycle still beats the timeout.
                    if (i_bus_rdata_valid) begin
                        r_ir    <= i_instr;
                        r_state <= ST_DECODE;
                    end else if (w_timeout) begin
                        r_state <= ST_FAULT;
                        r_fault <= c_FAULT_TIMEOUT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_illegal) begin
                        r_state <= ST_FAULT;
                        r_fault <= c_FAULT_ILLEGAL;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_is_mem) begin
                        r_state <= ST_MEM;
                        r_wait  <= '0;
                        r_first <= 1'b1;
                    end
                end
                ST_MEM: begin
                    if (!w_mem_ack) begin
                        if (w_timeout) begin
                            r_state <= ST_FAULT;
                            r_fault <= c_FAULT_TIMEOUT;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end
                end
                ST_FAULT: ;
                default: r_state <= ST_IDLE;
            endcase

            if (w_retire) begin
                r_count <= r_count + 1'b1;
                if (i_run) begin
                    r_state <= ST_FETCH;
                    r_wait  <= '0;
                    r_first <= 1'b1;
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        o_reg_wen      = 1'b0;
        o_reg_wsel     = c_WSEL_ALU;
        o_alu_op       = 1'b0;
        o_alu_a_sel    = 1'b0;
        o_alu_b_sel    = 1'b0;
        o_pc_en        = 1'b0;
        o_pc_sel       = c_PCSEL_SEQ;
        o_bus_start    = 1'b0;
        o_bus_we       = 1'b0;
        o_bus_addr_sel = 1'b0;
        case (r_state)
            ST_FETCH: o_bus_start = r_first;
            ST_EXEC: begin
                if (w_cls[c_CLS_ADD] || w_cls[c_CLS_SUB] || w_cls[c_CLS_ADDI]) begin
                    o_reg_wen   = 1'b1;
                    o_alu_op    = w_cls[c_CLS_SUB];
                    o_alu_b_sel = w_cls[c_CLS_ADDI];
                    o_pc_en     = 1'b1;
                end
                if (w_cls[c_CLS_LUI]) begin
                    o_reg_wen  = 1'b1;
                    o_reg_wsel = c_WSEL_IMM;
                    o_pc_en    = 1'b1;
                end
                if (w_cls[c_CLS_JAL]) begin
                    o_reg_wen  = 1'b1;
                    o_reg_wsel = c_WSEL_PC4;
                    o_pc_en    = 1'b1;
                    o_pc_sel   = c_PCSEL_REL;
                end
                if (w_cls[c_CLS_BEQ]) begin
                    o_alu_op = 1'b1;
                    o_pc_en  = 1'b1;
                    o_pc_sel = i_alu_zero;
                end
                if (w_is_mem) begin
                    o_alu_b_sel = 1'b1;
                end
            end
            ST_MEM: begin
                // Address computation rs1+imm stays on the ALU for the whole access.
                o_alu_b_sel    = 1'b1;
                o_bus_addr_sel = 1'b1;
                o_bus_start    = r_first;
                o_bus_we       = w_cls[c_CLS_SW];
                if (w_mem_ack) begin
                    o_pc_en = 1'b1;
                    if (w_cls[c_CLS_LW]) begin
                        o_reg_wen  = 1'b1;
                        o_reg_wsel = c_WSEL_MEM;
                    end
                end
            end
            default: ;
        endcase
        if (o_reg_rd == 5'd0) begin
            o_reg_wen = 1'b0;
        end
    end

    assign o_reg_rs1     = r_ir[19:15];
    assign o_reg_rs2     = r_ir[24:20];
    assign o_reg_rd      = r_ir[11:7];
    assign o_state       = r_state;
    assign o_halted      = (r_state == ST_FAULT);
    assign o_fault       = r_fault;
    assign o_instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl_unit
// Brief    : Self-checking bench: instruction vector table in step mode plus
//            run-mode, timeout, illegal-opcode and reset-mid-access sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl_unit;

    localparam int XLEN        = 32;
    localparam int BUS_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_run, i_step;
    logic [31:0]      i_instr;
    logic             i_bus_rdata_valid, i_bus_write_done, i_alu_zero;
    logic [4:0]       o_reg_rs1, o_reg_rs2, o_reg_rd;
    logic             o_reg_wen;
    logic [1:0]       o_reg_wsel;
    logic [XLEN-1:0]  o_imm;
    logic             o_alu_op, o_alu_a_sel, o_alu_b_sel;
    logic             o_pc_en, o_pc_sel;
    logic             o_bus_start, o_bus_we, o_bus_addr_sel;
    logic [2:0]       o_state;
    logic             o_halted;
    logic [1:0]       o_fault;
    logic [CNT_W-1:0] o_instr_count;

    always #5 clk = ~clk;

    multicycle_ctrl_unit #(
        .XLEN        (XLEN),
        .BUS_TIMEOUT (BUS_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_run             (i_run),
        .i_step            (i_step),
        .i_instr           (i_instr),
        .i_bus_rdata_valid (i_bus_rdata_valid),
        .i_bus_write_done  (i_bus_write_done),
        .i_alu_zero        (i_alu_zero),
        .o_reg_rs1         (o_reg_rs1),
        .o_reg_rs2         (o_reg_rs2),
        .o_reg_rd          (o_reg_rd),
        .o_reg_wen         (o_reg_wen),
        .o_reg_wsel        (o_reg_wsel),
        .o_imm             (o_imm),
        .o_alu_op          (o_alu_op),
        .o_alu_a_sel       (o_alu_a_sel),
        .o_alu_b_sel       (o_alu_b_sel),
        .o_pc_en           (o_pc_en),
        .o_pc_sel          (o_pc_sel),
        .o_bus_start       (o_bus_start),
        .o_bus_we          (o_bus_we),
        .o_bus_addr_sel    (o_bus_addr_sel),
        .o_state           (o_state),
        .o_halted          (o_halted),
        .o_fault           (o_fault),
        .o_instr_count     (o_instr_count)
    );

    // fd/md: wait cycle on which the fetch/memory ack arrives.
    // noise: raise both acks in IDLE, DECODE and EXEC where they must be ignored.
    typedef struct {
        logic [31:0] ins;
        logic        az;
        int          fd;
        int          md;
        logic        is_mem;
        logic        sw;
        logic        noise;
        logic        wen;
        logic [1:0]  wsel;
        logic        alu_op;
        logic        b_sel;
        logic        pc_sel;
        logic        imm_v;
        logic [31:0] imm;
    } vec_t;

    localparam int N_VEC = 13;
    vec_t vecs [N_VEC];

    int               n_chk  = 0;
    int               n_pass = 0;
    logic [CNT_W-1:0] exp_count;

    int          ob_bs, ob_wen, ob_pc;
    logic        ob_addr_f, ob_addr_m, ob_we_m, ob_pcsel, ob_op, ob_bsel, ob_mem_bsel;
    logic [1:0]  ob_wsel;
    logic [2:0]  ob_exec_state;
    logic [31:0] ob_imm;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic chk_quiet(input string tag, input logic full);
        chk({tag, ".strobes"}, {o_reg_wen, o_pc_en, o_bus_start}, 0);
        if (full)
            chk({tag, ".selects"}, {o_reg_wsel, o_alu_op, o_alu_a_sel, o_alu_b_sel,
                                    o_pc_sel, o_bus_we, o_bus_addr_sel}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_run = 1'b0; i_step = 1'b0; i_instr = '0;
        i_bus_rdata_valid = 1'b0; i_bus_write_done = 1'b0; i_alu_zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic exec_vec(input int idx, input vec_t v);
        int n_fetch = v.fd + 1;
        int n_mem   = v.is_mem ? v.md + 1 : 0;
        int total   = 1 + n_fetch + 2 + n_mem;
        ob_bs = 0; ob_wen = 0; ob_pc = 0;
        ob_addr_f = 1'bx; ob_addr_m = 1'bx; ob_we_m = 1'bx; ob_mem_bsel = 1'bx;
        ob_wsel = 2'bxx; ob_pcsel = 1'bx; ob_op = 1'bx; ob_bsel = 1'bx;
        ob_exec_state = 3'bxxx; ob_imm = 'x;
        for (int c = 0; c < total; c++) begin
            i_step = (c == 0);
            i_instr = v.ins;
            i_alu_zero = v.az;
            i_bus_rdata_valid = (c == v.fd + 1);
            i_bus_write_done = 1'b0;
            if (v.noise && (c == 0 || c == n_fetch + 1 || c == n_fetch + 2)) begin
                i_bus_rdata_valid = 1'b1;
                i_bus_write_done  = 1'b1;
            end
            if (v.is_mem && c == total - 1) begin
                i_bus_write_done  = v.sw;
                i_bus_rdata_valid = !v.sw;
            end
            @(negedge clk);
            if (o_bus_start) begin
                ob_bs++;
                if (ob_bs == 1) ob_addr_f = o_bus_addr_sel;
                else begin
                    ob_addr_m = o_bus_addr_sel;
                    ob_we_m = o_bus_we;
                    ob_mem_bsel = o_alu_b_sel;
                end
            end
            if (o_reg_wen) begin ob_wen++; ob_wsel = o_reg_wsel; end
            if (o_pc_en)   begin ob_pc++;  ob_pcsel = o_pc_sel; end
            if (c == n_fetch + 2) begin
                ob_exec_state = o_state;
                ob_op = o_alu_op;
                ob_bsel = o_alu_b_sel;
                ob_imm = o_imm;
            end
            @(posedge clk); #1;
        end
        i_step = 1'b0; i_bus_rdata_valid = 1'b0; i_bus_write_done = 1'b0;

        chk($sformatf("v%0d.exec_state", idx), ob_exec_state, 3);
        chk($sformatf("v%0d.bus_starts", idx), ob_bs, v.is_mem ? 2 : 1);
        chk($sformatf("v%0d.fetch_addr_sel", idx), ob_addr_f, 0);
        if (v.is_mem) begin
            chk($sformatf("v%0d.mem_addr_sel", idx), ob_addr_m, 1);
            chk($sformatf("v%0d.mem_we", idx), ob_we_m, v.sw);
            chk($sformatf("v%0d.mem_b_sel", idx), ob_mem_bsel, 1);
        end
        chk($sformatf("v%0d.wen_count", idx), ob_wen, v.wen ? 1 : 0);
        if (v.wen) chk($sformatf("v%0d.wsel", idx), ob_wsel, v.wsel);
        chk($sformatf("v%0d.pc_en_count", idx), ob_pc, 1);
        chk($sformatf("v%0d.pc_sel", idx), ob_pcsel, v.pc_sel);
        chk($sformatf("v%0d.alu_op", idx), ob_op, v.alu_op);
        chk($sformatf("v%0d.b_sel", idx), ob_bsel, v.b_sel);
        if (v.imm_v) chk($sformatf("v%0d.imm", idx), ob_imm, v.imm);
    endtask

    task automatic illegal_case(input string tag, input logic [31:0] ins);
        do_reset();
        i_instr = ins;
        for (int c = 0; c <= 3; c++) begin
            i_step = (c == 0);
            i_bus_rdata_valid = (c == 1);
            @(negedge clk);
            if (c == 2) chk({tag, ".decode_state"}, o_state, 2);
            if (c == 3) begin
                chk({tag, ".state"}, o_state, 5);
                chk({tag, ".fault"}, o_fault, 1);
                chk({tag, ".halted"}, o_halted, 1);
                chk({tag, ".count"}, o_instr_count, 0);
                chk_quiet({tag, ".fault"}, 1'b0);
            end
            @(posedge clk); #1;
        end
        i_bus_rdata_valid = 1'b0;
        i_run = 1'b1;
        @(negedge clk);
        chk({tag, ".sticky"}, o_state, 5);
        @(posedge clk); #1;
        i_run = 1'b0;
    endtask

    initial begin
        //          ins           az  fd  md mem sw  nz wen wsel op  b  pcs immv imm
        vecs[0]  = '{32'h00500093, 0,  2,  0, 0, 0, 0, 1, 2'd0, 0, 1, 0, 1, 32'h00000005}; // ADDI x1,x0,5
        vecs[1]  = '{32'hFFF00093, 0,  0,  0, 0, 0, 0, 1, 2'd0, 0, 1, 0, 1, 32'hFFFFFFFF}; // ADDI x1,x0,-1
        vecs[2]  = '{32'h002081B3, 0, 15,  0, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 32'h0};        // ADD x3,x1,x2
        vecs[3]  = '{32'h402081B3, 0,  1,  0, 0, 0, 0, 1, 2'd0, 1, 0, 0, 0, 32'h0};        // SUB x3,x1,x2
        vecs[4]  = '{32'h123452B7, 0,  0,  0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 1, 32'h12345000}; // LUI x5,0x12345
        vecs[5]  = '{32'hFFFFF2B7, 0,  0,  0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 1, 32'hFFFFF000}; // LUI x5,0xFFFFF
        vecs[6]  = '{32'hFF9FF0EF, 0,  1,  0, 0, 0, 0, 1, 2'd3, 0, 0, 1, 1, 32'hFFFFFFF8}; // JAL x1,-8
        vecs[7]  = '{32'hFE108CE3, 1,  0,  0, 0, 0, 0, 0, 2'd0, 1, 0, 1, 1, 32'hFFFFFFF8}; // BEQ taken
        vecs[8]  = '{32'hFE108CE3, 0,  0,  0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 1, 32'hFFFFFFF8}; // BEQ not taken
        vecs[9]  = '{32'h00208033, 0,  0,  0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 32'h0};        // ADD x0,x1,x2
        vecs[10] = '{32'h0040A103, 0,  1,  1, 1, 0, 1, 1, 2'd1, 0, 1, 0, 1, 32'h00000004}; // LW x2,4(x1)
        vecs[11] = '{32'h0020A423, 0,  0,  3, 1, 1, 0, 0, 2'd0, 0, 1, 0, 1, 32'h00000008}; // SW x2,8(x1)
        vecs[12] = '{32'h0040A103, 0,  0, 15, 1, 0, 0, 1, 2'd1, 0, 1, 0, 1, 32'h00000004}; // LW, late ack

        do_reset();
        @(negedge clk);
        chk("reset.state", o_state, 0);
        chk("reset.count", o_instr_count, 0);
        chk("reset.fault", {o_halted, o_fault}, 0);
        chk("reset.ir_fields", {o_reg_rs1, o_reg_rs2, o_reg_rd, o_imm}, 0);
        chk_quiet("reset", 1'b1);
        @(posedge clk); #1;

        // Run mode: ADDI with fetch ack on wait cycle 2, then back-to-back fetch.
        i_run = 1'b1;
        i_instr = 32'h00500093;
        for (int c = 0; c <= 5; c++) begin
            i_bus_rdata_valid = (c == 3);
            @(negedge clk);
            if (c == 1) chk("run.fetch_start", {o_bus_start, o_bus_we, o_bus_addr_sel}, 3'b100);
            if (c == 2) chk("run.fetch_single_start", o_bus_start, 0);
            if (c == 5) begin
                chk("run.exec_state", o_state, 3);
                chk("run.exec_ctrl", {o_reg_wen, o_reg_wsel, o_alu_op, o_alu_b_sel, o_pc_en, o_pc_sel},
                    {1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0});
                chk("run.imm", o_imm, 5);
            end
            @(posedge clk); #1;
        end
        i_bus_rdata_valid = 1'b0;
        i_run = 1'b0;
        @(negedge clk);
        chk("run.refetch_state", o_state, 1);
        chk("run.refetch_start", o_bus_start, 1);
        chk("run.count", o_instr_count, 1);
        @(posedge clk); #1;

        // Withhold the fetch ack for the whole timeout window.
        begin
            int starts = 0;
            for (int w = 1; w < BUS_TIMEOUT; w++) begin
                @(negedge clk);
                starts += int'(o_bus_start);
                if (w == BUS_TIMEOUT - 1) chk("timeout.last_wait_state", o_state, 1);
                @(posedge clk); #1;
            end
            chk("timeout.no_restart", starts, 0);
        end
        @(negedge clk);
        chk("timeout.state", o_state, 5);
        chk("timeout.fault", o_fault, 2);
        chk("timeout.halted", o_halted, 1);
        @(posedge clk); #1;
        begin
            int bad = 0;
            i_run = 1'b1; i_step = 1'b1; i_bus_rdata_valid = 1'b1; i_bus_write_done = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (o_state !== 3'd5 || o_reg_wen || o_pc_en || o_bus_start) bad++;
                @(posedge clk); #1;
            end
            chk("fault.sticky_quiet", bad, 0);
            chk("fault.count_frozen", o_instr_count, 1);
        end

        do_reset();
        exp_count = '0;
        for (int i = 0; i < N_VEC; i++) begin
            exec_vec(i, vecs[i]);
            exp_count = exp_count + 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d.back_to_idle", i), o_state, 0);
            chk($sformatf("v%0d.count", i), o_instr_count, exp_count);
            @(posedge clk); #1;
        end

        // Reset while an LW is waiting in MEM.
        i_instr = 32'h0040A103;
        for (int c = 0; c <= 5; c++) begin
            i_step = (c == 0);
            i_bus_rdata_valid = (c == 1);
            rst = (c == 5);
            @(negedge clk);
            if (c == 4) chk("rstmem.mem_start", {o_bus_start, o_bus_addr_sel}, 2'b11);
            if (c == 5) chk("rstmem.in_mem", o_state, 4);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        i_step = 1'b0;
        i_bus_rdata_valid = 1'b0;
        @(negedge clk);
        chk("rstmem.state", o_state, 0);
        chk("rstmem.count", o_instr_count, 0);
        chk("rstmem.ir_fields", {o_reg_rd, o_imm}, 0);
        chk_quiet("rstmem", 1'b1);
        @(posedge clk); #1;
        i_bus_rdata_valid = 1'b1;
        @(negedge clk);
        chk("rstmem.no_reissue", {o_state, o_bus_start}, 0);
        @(posedge clk); #1;
        i_bus_rdata_valid = 1'b0;

        illegal_case("ill_opcode", 32'h0000007F);
        illegal_case("ill_funct7", 32'h022081B3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
